// File: rtl/uart_rx_port_if.sv
// CPU-side run/done toggle bus for the UART receive device.
// The master raises a request by toggling bus_run; the slave answers by toggling bus_done.
interface uart_rx_port_if;
  logic [15:0] bus_addr;
  logic [1:0]  bus_cmd;
  logic        bus_run;
  logic [15:0] bus_rd_data;
  logic        bus_done;

  modport master (
    output bus_addr, bus_cmd, bus_run,
    input  bus_rd_data, bus_done
  );

  modport slave (
    input  bus_addr, bus_cmd, bus_run,
    output bus_rd_data, bus_done
  );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver feeding a small FIFO, read by the CPU through a data and a status register
// over the run/done toggle bus.
module uart_rx_port #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] ADDR_DATA  = 16'h0002,
  parameter logic [15:0] ADDR_STAT  = 16'h0003
) (
  input  logic          sysclk,
  input  logic          reset_n,
  input  logic          uart_rxp,
  uart_rx_port_if.slave bus,
  output logic          rx_irq
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int          CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int          PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT1    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rx_meta_q, rxs_q, run_meta_q, run_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             done_q, done_d, irq_q, irq_d;

  logic push_evt, fe_evt, push_ok, ovr_evt, pop;
  logic req, is_rd, data_sel, stat_sel, stat_rd, full, nonempty;

  // Receive FSM: one down-counter times both the half-bit start check and full bit periods.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_evt = 1'b0;
    fe_evt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = DIV_M1;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = DIV_M1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          push_evt = rxs_q;
          fe_evt   = !rxs_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    endcase
  end

  // Bus decode, FIFO bookkeeping and sticky error flags.
  always_comb begin
    req      = (run_s_q != done_q);
    is_rd    = (bus.bus_cmd == 2'b00) || (bus.bus_cmd == 2'b10);
    data_sel = (bus.bus_addr == ADDR_DATA);
    stat_sel = (bus.bus_addr == ADDR_STAT);
    full     = (count_q == DEPTH_C);
    nonempty = (count_q != '0);
    pop      = req && is_rd && data_sel && nonempty;
    stat_rd  = req && is_rd && stat_sel;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_ok  = push_evt && (!full || pop);
    ovr_evt  = push_evt && full && !pop;

    done_d    = req ? ~done_q : done_q;
    rd_data_d = rd_data_q;
    if (req && is_rd && data_sel) begin
      rd_data_d = nonempty ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
    end else if (stat_rd) begin
      rd_data_d = {12'h000, frame_err_q, overrun_q, full, nonempty};
    end

    overrun_d   = (overrun_q && !stat_rd) || ovr_evt;
    frame_err_d = (frame_err_q && !stat_rd) || fe_evt;
    wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT1;
      2'b01:   count_d = count_q - CNT1;
      default: count_d = count_q;
    endcase
    irq_d = (count_d != '0);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_data_q   <= 16'h0000;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rxp;
      rxs_q       <= rx_meta_q;
      run_meta_q  <= bus.bus_run;
      run_s_q     <= run_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
    end
  end

  always_ff @(posedge sysclk) begin
    shift_q <= shift_d;
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus.bus_rd_data = rd_data_q;
  assign bus.bus_done    = done_q;
  assign rx_irq          = irq_q;

endmodule
